// File: rtl/pipe_pkg.sv
// Shared defaults for the pipeline register stage: field widths, ctrl-bit indices
// and the default mask of ctrl bits that must read 0 on a bubble.
package pipe_pkg;

   localparam int unsigned DATA_W_DEF = 64;
   localparam int unsigned CTRL_W_DEF = 2;
   localparam int unsigned REG_W_DEF  = 5;

   localparam int unsigned CTRL_REGWRITE = 0;
   localparam int unsigned CTRL_MEMTOREG = 1;

   // Only RegWrite can corrupt architectural state if it leaks out of a bubble.
   localparam logic [CTRL_W_DEF-1:0] KILL_MASK_DEF = CTRL_W_DEF'(1 << CTRL_REGWRITE);

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus ctrl/data/WriteReg payload.
// clear drops only the valid bit so the payload keeps its last contents.
module pipe_slot #(
   parameter int unsigned DATA_W = pipe_pkg::DATA_W_DEF,
   parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF,
   parameter int unsigned REG_W  = pipe_pkg::REG_W_DEF
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   input  logic [REG_W-1:0]  d_wreg,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data,
   output logic [REG_W-1:0]  wreg
);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
         wreg  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= d_ctrl;
         data  <= d_data;
         wreg  <= d_wreg;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a one-entry skid buffer, flush, bubble masking of
// selected ctrl bits and a saturating backpressure counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W    = DATA_W_DEF,
   parameter int unsigned       CTRL_W    = CTRL_W_DEF,
   parameter int unsigned       REG_W     = REG_W_DEF,
   parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'(KILL_MASK_DEF)
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [REG_W-1:0]  in_WriteReg,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [REG_W-1:0]  out_WriteReg,
   output logic [15:0]       stall_cnt
);

   logic              main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_d_data;
   logic [REG_W-1:0]  main_wreg, skid_wreg, main_d_wreg;
   logic              accept, drain;
   logic              main_load, main_clear, skid_load, skid_clear;

   // skid_valid is a flop output, so in_ready never depends on out_ready combinationally.
   assign in_ready = ~skid_valid;
   assign accept   = in_valid & in_ready & ~flush;
   assign drain    = main_valid & out_ready;

   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (drain) begin
         skid_clear = 1'b1;
         if (skid_valid || accept) begin
            main_load = 1'b1;
         end else begin
            main_clear = 1'b1;
         end
      end else if (accept) begin
         if (main_valid) begin
            skid_load = 1'b1;
         end else begin
            main_load = 1'b1;
         end
      end
   end

   // A full skid forces in_ready low, so skid and input never compete for main.
   always_comb begin
      main_d_ctrl = in_ctrl;
      main_d_data = in_data;
      main_d_wreg = in_WriteReg;
      if (skid_valid) begin
         main_d_ctrl = skid_ctrl;
         main_d_data = skid_data;
         main_d_wreg = skid_wreg;
      end
   end

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .REG_W  (REG_W)
   ) u_main (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .load   (main_load),
      .clear  (main_clear),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .d_wreg (main_d_wreg),
      .valid  (main_valid),
      .ctrl   (main_ctrl),
      .data   (main_data),
      .wreg   (main_wreg)
   );

   pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .REG_W  (REG_W)
   ) u_skid (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .d_wreg (in_WriteReg),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data),
      .wreg   (skid_wreg)
   );

   assign out_valid    = main_valid;
   assign out_ctrl     = main_valid ? main_ctrl : (main_ctrl & ~KILL_MASK);
   assign out_data     = main_data;
   assign out_WriteReg = main_wreg;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: streaming, backpressure, flush,
// reset mid-transfer, counter saturation and bubble masking.
module tb_pipe_stage_skid;

   logic        CLK = 1'b0;
   logic        RSTn;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_ctrl;
   logic [63:0] in_data;
   logic [4:0]  in_WriteReg;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ctrl;
   logic [63:0] out_data;
   logic [4:0]  out_WriteReg;
   logic [15:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   pipe_stage_skid dut (
      .CLK          (CLK),
      .RSTn         (RSTn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ctrl      (in_ctrl),
      .in_data      (in_data),
      .in_WriteReg  (in_WriteReg),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ctrl     (out_ctrl),
      .out_data     (out_data),
      .out_WriteReg (out_WriteReg),
      .stall_cnt    (stall_cnt)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      step();
      RSTn = 1'b1;
   endtask

   task automatic drive(input logic [63:0] d, input logic [1:0] c, input logic [4:0] r);
      in_valid = 1'b1;
      in_data = d;
      in_ctrl = c;
      in_WriteReg = r;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_tests++; if (out_ctrl !== 2'b00) begin n_fail++; $display("FAIL reset_out_ctrl got %0b want 00", out_ctrl); end
      n_tests++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
      n_tests++; if (out_WriteReg !== 5'd0) begin n_fail++; $display("FAIL reset_out_wreg got %0d want 0", out_WriteReg); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_streaming();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(64'(i), 2'b01, 5'(i));
         step();
         n_tests++; if (out_valid !== 1'b1 || out_data !== 64'(i) || out_WriteReg !== 5'(i)) begin
            n_fail++; $display("FAIL stream_beat%0d got v=%0b d=%0h r=%0d want v=1 d=%0h r=%0d",
                               i, out_valid, out_data, out_WriteReg, i, i);
         end
         n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready%0d got %0b want 1", i, in_ready); end
      end
      in_valid = 1'b0;
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end_valid got %0b want 0", out_valid); end
      n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_stall_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      drive(64'hA, 2'b01, 5'd10);
      step();
      drive(64'hB, 2'b01, 5'd11);
      step();
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %0b want 0", in_ready); end
      drive(64'hC, 2'b01, 5'd12);
      step();
      n_tests++; if (out_data !== 64'hA || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold_A got v=%0b d=%0h want v=1 d=a", out_valid, out_data);
      end
      n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_stall_cnt got %0d want 2", stall_cnt); end
      out_ready = 1'b1;
      step();
      n_tests++; if (out_data !== 64'hB || out_WriteReg !== 5'd11) begin
         n_fail++; $display("FAIL bp_out_B got d=%0h r=%0d want d=b r=11", out_data, out_WriteReg);
      end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_free got %0b want 1", in_ready); end
      step();
      n_tests++; if (out_data !== 64'hC || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_out_C got v=%0b d=%0h want v=1 d=c", out_valid, out_data);
      end
      in_valid = 1'b0;
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", out_valid); end
      n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_stall_final got %0d want 2", stall_cnt); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b0;
      drive(64'hA, 2'b11, 5'd1);
      step();
      drive(64'hB, 2'b11, 5'd2);
      step();
      drive(64'hD, 2'b11, 5'd4);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
      n_tests++; if (out_ctrl !== 2'b10) begin n_fail++; $display("FAIL flush_ctrl got %0b want 10", out_ctrl); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
      n_tests++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL flush_stall_cnt got %0d want 2", stall_cnt); end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_tests++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_ghost%0d got v=%0b d=%0h want v=0", i, out_valid, out_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      drive(64'h1234, 2'b11, 5'd7);
      step();
      drive(64'h5678, 2'b11, 5'd8);
      step();
      step();
      RSTn = 1'b0;
      flush = 1'b1;
      step();
      RSTn = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 2'b00 || out_data !== 64'd0 || out_WriteReg !== 5'd0) begin
         n_fail++; $display("FAIL midrst_outputs got v=%0b c=%0b d=%0h r=%0d want all 0",
                            out_valid, out_ctrl, out_data, out_WriteReg);
      end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
      n_tests++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_stall_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_saturation();
      do_reset();
      out_ready = 1'b0;
      drive(64'h99, 2'b01, 5'd3);
      step();
      in_valid = 1'b0;
      repeat (65534) @(posedge CLK);
      #1;
      n_tests++; if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %0h want fffe", stall_cnt); end
      step();
      n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit got %0h want ffff", stall_cnt); end
      repeat (4500) @(posedge CLK);
      #1;
      n_tests++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %0h want ffff", stall_cnt); end
      n_tests++; if (out_valid !== 1'b1 || out_data !== 64'h99) begin
         n_fail++; $display("FAIL sat_beat got v=%0b d=%0h want v=1 d=99", out_valid, out_data);
      end
   endtask

   task automatic test_bubble();
      do_reset();
      out_ready = 1'b1;
      drive(64'h55, 2'b11, 5'd9);
      step();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_ctrl !== 2'b11) begin
         n_fail++; $display("FAIL bubble_live got v=%0b c=%0b want v=1 c=11", out_valid, out_ctrl);
      end
      step();
      n_tests++; if (out_valid !== 1'b0 || out_ctrl !== 2'b10) begin
         n_fail++; $display("FAIL bubble_masked got v=%0b c=%0b want v=0 c=10", out_valid, out_ctrl);
      end
      n_tests++; if (out_data !== 64'h55 || out_WriteReg !== 5'd9) begin
         n_fail++; $display("FAIL bubble_hold got d=%0h r=%0d want d=55 r=9", out_data, out_WriteReg);
      end
   endtask

   initial begin
      RSTn = 1'b0;
      in_valid = 1'b0;
      in_ctrl = 2'b00;
      in_data = 64'd0;
      in_WriteReg = 5'd0;
      flush = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_bubble();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 64, payload width (ALU result + read data).
REQ-002 Parameter CTRL_W, default 2, control-field width (bit0 RegWrite, bit1 MemtoReg).
REQ-003 Parameter REG_W, default 5, destination-register index width.
REQ-004 Parameter KILL_MASK, CTRL_W bits, default 2'b01, control bits forced to 0 whenever out_valid is 0.
REQ-005 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-006 RSTn  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  stage can accept a beat this cycle.
REQ-009 in_ctrl  in  CTRL_W  upstream control field.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 in_WriteReg  in  REG_W  upstream destination register.
REQ-012 flush  in  1  discard all held and incoming beats.
REQ-013 out_valid  out  1  downstream beat present.
REQ-014 out_ready  in  1  downstream accepts beat.
REQ-015 out_ctrl, out_data, out_WriteReg  out  CTRL_W/DATA_W/REG_W  downstream fields.
REQ-016 stall_cnt  out  16  saturating count of backpressure cycles.

Function
REQ-017 Storage: main slot (drives outputs) plus one skid slot; each slot holds valid, ctrl, data, WriteReg.
REQ-018 in_ready SHALL equal NOT skid.valid, registered (no combinational path from out_ready).
REQ-019 Accept = in_valid AND in_ready AND NOT flush; Drain = out_valid AND out_ready.
REQ-020 Latency: an accepted beat into an empty stage appears on out_* the next cycle.
REQ-021 On Drain: main loads skid if skid.valid (skid empties), else loads input if Accept, else main.valid <= 0.
REQ-022 No Drain, main empty, Accept: main loads input.
REQ-023 No Drain, main full, Accept: skid loads input.
REQ-024 Simultaneous Drain and Accept with skid full impossible (in_ready=0); with skid empty the input passes to main, skid stays empty.
REQ-025 Beat order SHALL be preserved; no beat duplicated or dropped except by flush.
REQ-026 flush=1: both valid bits cleared next cycle, incoming beat discarded, in_ready=1 next cycle; flush overrides Drain and Accept.
REQ-027 out_ctrl bits set in KILL_MASK SHALL read 0 when out_valid=0; other out_* fields hold last contents.
REQ-028 stall_cnt increments by 1 each cycle with out_valid=1 AND out_ready=0, saturates at 16'hFFFF, unaffected by flush.

Reset
REQ-029 RSTn=0 at posedge CLK: main.valid=0, skid.valid=0, stored ctrl/data/WriteReg=0, stall_cnt=0.
REQ-030 After reset: out_valid=0, out_ctrl=0, out_data=0, out_WriteReg=0, in_ready=1.
REQ-031 Reset mid-transfer drops all held beats; reset has priority over flush.

Structure
REQ-032 Package pipe_pkg holds default widths (DATA_W, CTRL_W, REG_W), ctrl-bit index constants (CTRL_REGWRITE=0, CTRL_MEMTOREG=1) and default KILL_MASK.
REQ-033 One sub-module pipe_slot (valid + payload register with load/clear) instantiated twice (main, skid).

Verification
REQ-034 Streaming: in_valid=1, out_ready=1, data 1..8 -> out_data 1..8 one cycle later each, in_ready stays 1, stall_cnt=0.
REQ-035 Backpressure: out_ready=0 while sending A,B,C -> A in main, B in skid, in_ready=0, C held upstream; out_ready=1 -> A,B,C out in order, stall_cnt counts held cycles.
REQ-036 Flush: main=A, skid=B, flush=1 with in_valid=1 (D) -> next cycle out_valid=0, out_ctrl[0]=0, in_ready=1, D never appears.
REQ-037 Reset mid-operation: RSTn=0 with both slots full -> next cycle all outputs 0, in_ready=1, stall_cnt=0.
REQ-038 Saturation: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-039 Bubble masking: in_ctrl=2'b11 beat drained, no new beat -> out_valid=0, out_ctrl=2'b10.
